// File: rtl/result_relu_writer.sv
// Streams the MAC result matrix back from result SRAM, applies ReLU, and writes a {rows,cols}-headed copy to output SRAM.
// Job length N+3 cycles accept-to-last-write; optional `RESULT_RELU_NEGCOUNT_EN adds a negative-element counter.
module result_relu_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              post_valid,
    output logic              post_ready,
    input  logic [15:0]       result_num_rows,
    input  logic [15:0]       result_num_cols,
    input  logic [ADDR_W-1:0] out_write_base_address,
    output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
    input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
    output logic              dut__tb__sram_output_write_enable,
    output logic [ADDR_W-1:0] dut__tb__sram_output_write_address,
    output logic [DATA_W-1:0] dut__tb__sram_output_write_data
`ifdef RESULT_RELU_NEGCOUNT_EN
    ,
    output logic [ADDR_W-1:0] relu_neg_count
`endif
);

    typedef enum logic [1:0] {IDLE, HEADER, STREAM, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       n_q;
    logic [31:0]       idx_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] pipe_addr_q;
    logic              rd_vld_q;
    logic              drain_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              accept;
    logic              last_issue;
    logic              neg_elem;
    logic [DATA_W-1:0] relu_d;

    assign accept     = (state_q == IDLE) && post_valid;
    assign last_issue = (idx_q == n_q - 32'd1);
    assign neg_elem   = tb__dut__sram_result_read_data[DATA_W-1];
    assign relu_d     = neg_elem ? '0 : tb__dut__sram_result_read_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (post_valid) state_d = HEADER;
            HEADER:  state_d = (n_q == 32'd0) ? IDLE : STREAM;
            STREAM:  if (last_issue) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        post_ready = (state_q == IDLE);
    end

    // Read side: address k is on the bus while idx_q==k; its data lands one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q         <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            raddr_q     <= '0;
            pipe_addr_q <= '0;
            rd_vld_q    <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            rd_vld_q <= (state_q == STREAM);
            drain_q  <= (state_q == DRAIN);
            if (state_q == STREAM)
                pipe_addr_q <= base_q + raddr_q + ADDR_W'(1);
            if (accept) begin
                n_q     <= 32'(result_num_rows) * 32'(result_num_cols);
                base_q  <= out_write_base_address;
                raddr_q <= '0;
                idx_q   <= '0;
            end else if ((state_q == STREAM) && !last_issue) begin
                raddr_q <= raddr_q + ADDR_W'(1);
                idx_q   <= idx_q + 32'd1;
            end
        end
    end

    // Header is registered on the accept edge so it strobes during HEADER.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= 1'b1;
            waddr_q <= out_write_base_address;
            wdata_q <= DATA_W'({result_num_rows, result_num_cols});
        end else if (rd_vld_q) begin
            we_q    <= 1'b1;
            waddr_q <= pipe_addr_q;
            wdata_q <= relu_d;
        end else begin
            we_q    <= 1'b0;
        end
    end

`ifdef RESULT_RELU_NEGCOUNT_EN
    logic [ADDR_W-1:0] neg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            neg_q <= '0;
        else if (accept)
            neg_q <= '0;
        else if (rd_vld_q && neg_elem && (neg_q != '1))
            neg_q <= neg_q + ADDR_W'(1);
    end

    assign relu_neg_count = neg_q;
`endif

    assign dut__tb__sram_result_read_address  = raddr_q;
    assign dut__tb__sram_output_write_enable  = we_q;
    assign dut__tb__sram_output_write_address = waddr_q;
    assign dut__tb__sram_output_write_data    = wdata_q;

endmodule
